mux_lanes_param: RTL

//  Parametrised successor of the L1 4->2 byte mux: folds NUM_IN input lanes onto
//  NUM_OUT output lanes on one clock (R = NUM_IN/NUM_OUT slots per group).

---
 rtl/mux_lanes_param.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mux_lanes_param.sv
// Folds NUM_IN input lanes onto NUM_OUT output lanes, R = NUM_IN/NUM_OUT slots per group,
// with a double-buffered ready/valid input. Optional MUX_ERRCNT_EN adds a saturating err_count.
//
// state    | meaning
// ---------+-----------------------------------------------------
// S_IDLE   | shift buffer empty, outputs idle
// S_ACTIVE | shift buffer holds a group, slot cnt is on the output
module mux_lanes_param #(
  parameter int               WIDTH    = 8,
  parameter int               NUM_IN   = 4,
  parameter int               NUM_OUT  = 2,
  parameter logic [WIDTH-1:0] IDLE_SYM = 8'hBC
) (
  input  logic                       clk_4f,
  input  logic                       reset,
  input  logic [NUM_IN*WIDTH-1:0]    in_data,
  input  logic [NUM_IN-1:0]          in_lvalid,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [NUM_OUT*WIDTH-1:0]   out_data,
  output logic [NUM_OUT-1:0]         out_valid,
  output logic                       idle_out
`ifdef MUX_ERRCNT_EN
  , output logic [15:0]              err_count
`endif
);

  localparam int R  = NUM_IN / NUM_OUT;
  localparam int CW = (R > 1) ? $clog2(R) : 1;
  localparam logic [CW-1:0] LAST = CW'(R - 1);

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t                    state;
  logic [NUM_IN*WIDTH-1:0]   cap_data, shf_data, sel_data;
  logic [NUM_IN-1:0]         cap_lv, shf_lv, sel_lv;
  logic                      cap_full, shf_full, armed;
  logic [CW-1:0]             cnt, sel_slot;
  logic                      xfer, accept, sel_en, last_slot;
  logic                      cap_full_nxt, shf_full_nxt;
  logic [NUM_OUT*WIDTH-1:0]  nxt_data;
  logic [NUM_OUT-1:0]        nxt_valid;

  assign shf_full     = (state == S_ACTIVE);
  assign last_slot    = (cnt == LAST);
  assign xfer         = cap_full & (!shf_full | last_slot);
  // armed holds in_ready low until the first edge after reset release
  assign in_ready     = armed & (!cap_full | xfer);
  assign accept       = in_valid & in_ready;
  assign cap_full_nxt = accept | (cap_full & !xfer);
  assign shf_full_nxt = xfer | (shf_full & !last_slot);

  // Next slot to present: slot 0 of the group moving in, or the next slot of shf
  assign sel_en   = xfer | (shf_full & !last_slot);
  assign sel_data = xfer ? cap_data : shf_data;
  assign sel_lv   = xfer ? cap_lv : shf_lv;
  assign sel_slot = xfer ? '0 : cnt + CW'(1);

  always_comb begin
    nxt_data  = {NUM_OUT{IDLE_SYM}};
    nxt_valid = '0;
    for (int j = 0; j < NUM_OUT; j++) begin
      for (int s = 0; s < R; s++) begin
        if (sel_en && (sel_slot == CW'(s)) && sel_lv[j*R+s]) begin
          nxt_valid[j]                 = 1'b1;
          nxt_data[j*WIDTH +: WIDTH]   = sel_data[(j*R+s)*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cap_data  <= '0;
      cap_lv    <= '0;
      cap_full  <= 1'b0;
      shf_data  <= '0;
      shf_lv    <= '0;
      cnt       <= '0;
      armed     <= 1'b0;
      out_data  <= {NUM_OUT{IDLE_SYM}};
      out_valid <= '0;
      idle_out  <= 1'b1;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        cap_data <= in_data;
        cap_lv   <= in_lvalid;
      end
      cap_full <= cap_full_nxt;

      case (state)
        S_IDLE: begin
          if (xfer) begin
            shf_data <= cap_data;
            shf_lv   <= cap_lv;
            cnt      <= '0;
            state    <= S_ACTIVE;
          end
        end
        S_ACTIVE: begin
          if (xfer) begin
            shf_data <= cap_data;
            shf_lv   <= cap_lv;
            cnt      <= '0;
          end else if (last_slot) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase

      out_data  <= nxt_data;
      out_valid <= nxt_valid;
      idle_out  <= !cap_full_nxt & !shf_full_nxt;
    end
  end

`ifdef MUX_ERRCNT_EN
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      err_count <= '0;
    end else if (in_valid && !in_ready && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule
